// File: rtl/led_pattern_ctrl.sv
// Multi-channel LED driver: OFF/ON/BLINK/BREATHE per channel,
// shared tick prescaler and PWM counter, one-cycle config writes.
module led_pattern_ctrl #(
    parameter int CLK_FREQ = 50000000,
    parameter int TICK_HZ  = 1000,
    parameter int NUM_LED  = 4,
    parameter int PWM_BITS = 8,
    parameter int HALF_W   = 16,
    parameter int DEF_HALF = 500
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [3:0]         cfg_ch,
    input  logic [1:0]         cfg_mode,
    input  logic [HALF_W-1:0]  cfg_half,
    output logic               tick,
    output logic [NUM_LED-1:0] led
);

    localparam int TICK_DIV = CLK_FREQ / TICK_HZ;
    localparam int PW       = $clog2(TICK_DIV);

    localparam logic [PW-1:0]       PRESC_TOP = PW'(TICK_DIV - 1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;
    localparam logic [PWM_BITS-1:0] DUTY_ONE  = PWM_BITS'(1);
    localparam logic [HALF_W-1:0]   HALF_ONE  = HALF_W'(1);
    localparam logic [HALF_W-1:0]   HALF_DEF  = HALF_W'(DEF_HALF);

    typedef enum logic [1:0] {
        M_OFF     = 2'd0,
        M_ON      = 2'd1,
        M_BLINK   = 2'd2,
        M_BREATHE = 2'd3
    } mode_e;

    logic [PW-1:0]       presc_q, presc_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic                tick_q, tick_d;
    logic [NUM_LED-1:0]  led_q, led_d;

    mode_e               mode_q [NUM_LED];
    mode_e               mode_d [NUM_LED];
    logic [HALF_W-1:0]   half_q [NUM_LED];
    logic [HALF_W-1:0]   half_d [NUM_LED];
    logic [HALF_W-1:0]   tcnt_q [NUM_LED];
    logic [HALF_W-1:0]   tcnt_d [NUM_LED];
    logic [PWM_BITS-1:0] duty_q [NUM_LED];
    logic [PWM_BITS-1:0] duty_d [NUM_LED];
    logic [NUM_LED-1:0]  blink_q, blink_d;
    logic [NUM_LED-1:0]  dir_q, dir_d;
    logic [NUM_LED-1:0]  step;
    logic [NUM_LED-1:0]  active;
    logic                cfg_hit;

    assign tick = tick_q;
    assign led  = led_q;

    always_comb begin
        presc_d = (presc_q == PRESC_TOP) ? '0 : presc_q + PW'(1);
        tick_d  = (presc_q == PRESC_TOP);
        pwm_d   = pwm_q + DUTY_ONE;
        cfg_hit = cfg_we && (32'(cfg_ch) < NUM_LED);
        mode_d  = mode_q;
        half_d  = half_q;
        tcnt_d  = tcnt_q;
        duty_d  = duty_q;
        blink_d = blink_q;
        dir_d   = dir_q;
        step    = '0;
        active  = '0;
        led_d   = '0;

        for (int i = 0; i < NUM_LED; i++) begin
            unique case (mode_q[i])
                M_OFF:     led_d[i] = 1'b0;
                M_ON:      led_d[i] = 1'b1;
                M_BLINK:   led_d[i] = blink_q[i];
                M_BREATHE: led_d[i] = (duty_q[i] > pwm_q);
            endcase

            active[i] = (mode_q[i] == M_BLINK) ||
                        (mode_q[i] == M_BREATHE);

            if (!active[i]) begin
                tcnt_d[i] = '0;
            end else if (tick_q) begin
                if (tcnt_q[i] == half_q[i] - HALF_ONE) begin
                    tcnt_d[i] = '0;
                    step[i]   = 1'b1;
                end else begin
                    tcnt_d[i] = tcnt_q[i] + HALF_ONE;
                end
            end

            // Breathing duty bounces between 0 and DUTY_MAX, never wraps.
            if (step[i] && mode_q[i] == M_BLINK) begin
                blink_d[i] = ~blink_q[i];
            end else if (step[i] && !dir_q[i]) begin
                duty_d[i] = duty_q[i] + DUTY_ONE;
                if (duty_q[i] == DUTY_MAX - DUTY_ONE) begin
                    dir_d[i] = 1'b1;
                end
            end else if (step[i]) begin
                duty_d[i] = duty_q[i] - DUTY_ONE;
                if (duty_q[i] == DUTY_ONE) begin
                    dir_d[i] = 1'b0;
                end
            end

            // A write on the same edge as a step overrides it.
            if (cfg_hit && cfg_ch == 4'(i)) begin
                mode_d[i]  = mode_e'(cfg_mode);
                half_d[i]  = (cfg_half == '0) ? HALF_ONE : cfg_half;
                tcnt_d[i]  = '0;
                duty_d[i]  = '0;
                blink_d[i] = 1'b0;
                dir_d[i]   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            pwm_q   <= '0;
            tick_q  <= 1'b0;
            led_q   <= '0;
            blink_q <= '0;
            dir_q   <= '0;
            for (int i = 0; i < NUM_LED; i++) begin
                mode_q[i] <= M_OFF;
                half_q[i] <= HALF_DEF;
                tcnt_q[i] <= '0;
                duty_q[i] <= '0;
            end
        end else begin
            presc_q <= presc_d;
            pwm_q   <= pwm_d;
            tick_q  <= tick_d;
            led_q   <= led_d;
            blink_q <= blink_d;
            dir_q   <= dir_d;
            for (int i = 0; i < NUM_LED; i++) begin
                mode_q[i] <= mode_d[i];
                half_q[i] <= half_d[i];
                tcnt_q[i] <= tcnt_d[i];
                duty_q[i] <= duty_d[i];
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Bench for led_pattern_ctrl: analytic per-edge expectations queued
// at each clock edge and compared on the following falling edge.
module tb_led_pattern_ctrl;

    localparam int NL = 4;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          cfg_we   = 1'b0;
    logic [3:0]    cfg_ch   = '0;
    logic [1:0]    cfg_mode = '0;
    logic [15:0]   cfg_half = '0;
    logic          tick;
    logic [NL-1:0] led;

    led_pattern_ctrl #(
        .CLK_FREQ(1000),
        .TICK_HZ (100),
        .NUM_LED (NL),
        .PWM_BITS(4),
        .HALF_W  (16),
        .DEF_HALF(500)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cfg_we  (cfg_we),
        .cfg_ch  (cfg_ch),
        .cfg_mode(cfg_mode),
        .cfg_half(cfg_half),
        .tick    (tick),
        .led     (led)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Channel descriptors: current and previous write (mode, half, edge).
    int cm [NL];
    int chf[NL];
    int cn [NL];
    int pm [NL];
    int phf[NL];
    int pn [NL];

    logic [NL:0] sb[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Ticks T = 10, 20, ... with T >= n (write edge) whose step edge T+1 <= m.
    function automatic int ticks_in(int n, int m);
        int lo;
        int hi;
        lo = (n > 10) ? n : 10;
        hi = m - 1;
        if (hi < lo) return 0;
        return hi / 10 - (lo - 1) / 10;
    endfunction

    function automatic bit chan_exp(int mode, int half, int n, int k);
        int s;
        int j;
        int duty;
        s    = ticks_in(n, k - 1) / half;
        j    = s % 30;
        duty = (j <= 15) ? j : 30 - j;
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return (s % 2) == 1;
            default: return duty > ((k - 1) % 16);
        endcase
    endfunction

    function automatic logic [NL:0] exp_at(int k);
        logic [NL:0] e;
        e[NL] = (k >= 10) && (k % 10 == 0);
        for (int i = 0; i < NL; i++) begin
            if (k > cn[i]) e[i] = chan_exp(cm[i], chf[i], cn[i], k);
            else           e[i] = chan_exp(pm[i], phf[i], pn[i], k);
        end
        return e;
    endfunction

    always @(posedge clk) begin
        if (rst_n) sb.push_back(exp_at(cyc + 1));
    end

    task automatic init_model();
        for (int i = 0; i < NL; i++) begin
            cm[i] = 0; chf[i] = 500; cn[i] = 0;
            pm[i] = 0; phf[i] = 500; pn[i] = 0;
        end
        sb.delete();
    endtask

    task automatic set_cfg(int ch, int mode, int half);
        cfg_we   = 1'b1;
        cfg_ch   = 4'(ch);
        cfg_mode = 2'(mode);
        cfg_half = 16'(half);
        if (ch < NL) begin
            pm[ch]  = cm[ch];
            phf[ch] = chf[ch];
            pn[ch]  = cn[ch];
            cm[ch]  = mode;
            chf[ch] = (half == 0) ? 1 : half;
            cn[ch]  = cyc + 1;
        end
    endtask

    task automatic test_reset();
        int nt;
        int first;
        logic [NL:0] e;
        init_model();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({tick, led} !== '0) begin
            n_err++;
            $display("FAIL reset_hold got=%b exp=0", {tick, led});
        end
        rst_n = 1'b1;
        nt = 0;
        first = -1;
        repeat (45) begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_vec++;
                if ({tick, led} !== e) begin
                    n_err++;
                    $display("FAIL sb_reset cyc=%0d got=%b exp=%b",
                             cyc, {tick, led}, e);
                end
            end
            if (tick === 1'b1) begin
                nt++;
                if (first < 0) first = cyc;
            end
        end
        n_vec++;
        if (first != 10 || nt != 4) begin
            n_err++;
            $display("FAIL tick_period first=%0d count=%0d exp 10/4",
                     first, nt);
        end
    endtask

    task automatic test_on_off();
        int n;
        logic [NL:0] e;
        set_cfg(0, 1, 5);
        n = cyc + 1;
        repeat (2) begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_vec++;
                if ({tick, led} !== e) begin
                    n_err++;
                    $display("FAIL sb_on cyc=%0d got=%b exp=%b",
                             cyc, {tick, led}, e);
                end
            end
            cfg_we = 1'b0;
            if (cyc == n) begin
                n_vec++;
                if (led[0] !== 1'b0) begin
                    n_err++;
                    $display("FAIL on_latency got=%b exp=0", led[0]);
                end
                set_cfg(1, 0, 7);
            end else begin
                n_vec++;
                if (led !== 4'b0001) begin
                    n_err++;
                    $display("FAIL on_applied got=%b exp=0001", led);
                end
            end
        end
        repeat (12) begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_vec++;
                if ({tick, led} !== e) begin
                    n_err++;
                    $display("FAIL sb_off cyc=%0d got=%b exp=%b",
                             cyc, {tick, led}, e);
                end
            end
            cfg_we = 1'b0;
        end
    endtask

    task automatic test_blink();
        int want;
        int last;
        logic prev;
        logic [NL:0] e;
        for (int ph = 0; ph < 2; ph++) begin
            want = (ph == 0) ? 30 : 10;
            set_cfg(2, 2, (ph == 0) ? 3 : 0);
            last = 0;
            prev = led[2];
            repeat ((ph == 0) ? 250 : 60) begin
                @(negedge clk);
                while (sb.size() > 0) begin
                    e = sb.pop_front();
                    n_vec++;
                    if ({tick, led} !== e) begin
                        n_err++;
                        $display("FAIL sb_blink cyc=%0d got=%b exp=%b",
                                 cyc, {tick, led}, e);
                    end
                end
                cfg_we = 1'b0;
                if (led[2] !== prev) begin
                    if (last > 0) begin
                        n_vec++;
                        if (cyc - last != want) begin
                            n_err++;
                            $display("FAIL blink_interval got=%0d exp=%0d",
                                     cyc - last, want);
                        end
                    end
                    last = cyc;
                    prev = led[2];
                end
            end
        end
    endtask

    task automatic test_breathe();
        int highs;
        logic [NL:0] e;
        set_cfg(3, 3, 1);
        highs = 0;
        repeat (650) begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_vec++;
                if ({tick, led} !== e) begin
                    n_err++;
                    $display("FAIL sb_breathe cyc=%0d got=%b exp=%b",
                             cyc, {tick, led}, e);
                end
            end
            cfg_we = 1'b0;
            if (led[3] === 1'b1) highs++;
        end
        n_vec++;
        if (highs == 0) begin
            n_err++;
            $display("FAIL breathe_active got=0 highs exp>0");
        end
    endtask

    task automatic test_invalid_and_collide();
        int n;
        int guard;
        logic [NL:0] e;
        set_cfg(4, 1, 5);
        repeat (20) begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_vec++;
                if ({tick, led} !== e) begin
                    n_err++;
                    $display("FAIL sb_invalid cyc=%0d got=%b exp=%b",
                             cyc, {tick, led}, e);
                end
            end
            cfg_we = 1'b0;
        end
        guard = 0;
        while (!(cyc % 10 == 0 && tick === 1'b1) && guard < 25) begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_vec++;
                if ({tick, led} !== e) begin
                    n_err++;
                    $display("FAIL sb_align cyc=%0d got=%b exp=%b",
                             cyc, {tick, led}, e);
                end
            end
            guard++;
        end
        n_vec++;
        if (guard >= 25) begin
            n_err++;
            $display("FAIL tick_align got=timeout exp=tick");
        end
        set_cfg(2, 2, 1);
        n = cyc + 1;
        repeat (30) begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_vec++;
                if ({tick, led} !== e) begin
                    n_err++;
                    $display("FAIL sb_collide cyc=%0d got=%b exp=%b",
                             cyc, {tick, led}, e);
                end
            end
            cfg_we = 1'b0;
            if (cyc == n + 1 || cyc == n + 9) begin
                n_vec++;
                if (led[2] !== 1'b0) begin
                    n_err++;
                    $display("FAIL collide_blink cyc=%0d got=%b exp=0",
                             cyc, led[2]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int first;
        logic [NL:0] e;
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({tick, led} !== '0) begin
            n_err++;
            $display("FAIL async_reset got=%b exp=0", {tick, led});
        end
        init_model();
        repeat (2) @(negedge clk);
        sb.delete();
        rst_n = 1'b1;
        first = -1;
        repeat (30) begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_vec++;
                if ({tick, led} !== e) begin
                    n_err++;
                    $display("FAIL sb_rst_mid cyc=%0d got=%b exp=%b",
                             cyc, {tick, led}, e);
                end
            end
            if (tick === 1'b1 && first < 0) first = cyc;
        end
        n_vec++;
        if (first != 10) begin
            n_err++;
            $display("FAIL rst_first_tick got=%0d exp=10", first);
        end
    endtask

    initial begin
        test_reset();
        test_on_off();
        test_blink();
        test_breathe();
        test_invalid_and_collide();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
